// File: rtl/logic_reduce_if.sv
// logic_reduce handshake bundle: beat input side and result output side.
// slave is the reducer's view, master is the source/sink view.
interface logic_reduce_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic [2:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_red;
   logic [2:0]       out_mode;
   logic [CNT_W-1:0] out_beats;

   modport slave (
      input  in_valid, in_data, in_last, mode, out_ready,
      output in_ready, out_valid, out_data, out_red,
      output out_mode, out_beats
   );

   modport master (
      output in_valid, in_data, in_last, mode, out_ready,
      input  in_ready, out_valid, out_data, out_red,
      input  out_mode, out_beats
   );
endinterface

// File: rtl/logic_reduce.sv
// logic_reduce: folds a packet of beats under OR/AND/XOR (optionally
// inverted) and emits one registered vector + scalar result per packet.
module logic_reduce #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   logic_reduce_if.slave  bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [1:0] OP_OR  = 2'd0;
   localparam logic [1:0] OP_AND = 2'd1;
   localparam logic [1:0] OP_XOR = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_mode;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_red;
   logic [2:0]       r_out_mode;
   logic [CNT_W-1:0] r_out_beats;

   logic             w_out_valid;
   logic             w_in_ready;
   logic             w_fire_in;
   logic             w_fire_out;
   logic             w_first;
   logic [2:0]       w_mode;
   logic [1:0]       w_op;
   logic             w_inv;
   logic [WIDTH-1:0] w_comb;
   logic [WIDTH-1:0] w_acc_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_red_raw;
   logic [WIDTH-1:0] w_res;
   logic             w_red;

   assign w_out_valid = (r_state == S_HOLD);
   assign w_in_ready  = !rst && (!w_out_valid || bus.out_ready);
   assign w_fire_in   = bus.in_valid && w_in_ready;
   assign w_fire_out  = w_out_valid && bus.out_ready;

   // A beat outside ACC always opens a new packet (HOLD never has a partial).
   assign w_first = (r_state != S_ACC);
   assign w_mode  = w_first ? bus.mode : r_mode;

   // Split mode into base operator and inversion flag.
   always_comb begin
      w_op  = OP_OR;
      w_inv = 1'b0;
      case (w_mode)
         3'd1: begin w_op = OP_OR;  w_inv = 1'b1; end
         3'd2: begin w_op = OP_AND; w_inv = 1'b0; end
         3'd3: begin w_op = OP_AND; w_inv = 1'b1; end
         3'd4: begin w_op = OP_XOR; w_inv = 1'b0; end
         3'd5: begin w_op = OP_XOR; w_inv = 1'b1; end
         default: begin w_op = OP_OR; w_inv = 1'b0; end
      endcase
   end

   // Combine accumulator with the incoming beat under the base operator.
   always_comb begin
      w_comb = r_acc | bus.in_data;
      unique case (1'b1)
         (w_op == OP_AND): w_comb = r_acc & bus.in_data;
         (w_op == OP_XOR): w_comb = r_acc ^ bus.in_data;
         default:          w_comb = r_acc | bus.in_data;
      endcase
   end

   assign w_acc_next = w_first ? bus.in_data : w_comb;

   // Beat counter saturates at all-ones instead of wrapping.
   always_comb begin
      w_cnt_next = CNT_W'(1);
      if (!w_first) begin
         w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
      end
   end

   // Scalar reduction of the final value under the same base operator.
   always_comb begin
      w_red_raw = |w_acc_next;
      unique case (1'b1)
         (w_op == OP_AND): w_red_raw = &w_acc_next;
         (w_op == OP_XOR): w_red_raw = ^w_acc_next;
         default:          w_red_raw = |w_acc_next;
      endcase
   end

   assign w_res = w_inv ? ~w_acc_next : w_acc_next;
   assign w_red = w_inv ? ~w_red_raw  : w_red_raw;

   // Packet FSM: accumulate beats, load result on last, drain on consume.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_mode      <= '0;
         r_out_data  <= '0;
         r_out_red   <= 1'b0;
         r_out_mode  <= '0;
         r_out_beats <= '0;
      end else if (w_fire_in) begin
         if (bus.in_last) begin
            r_state     <= S_HOLD;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= w_res;
            r_out_red   <= w_red;
            r_out_mode  <= w_mode;
            r_out_beats <= w_cnt_next;
         end else begin
            r_state <= S_ACC;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_mode  <= w_mode;
         end
      end else if (w_fire_out) begin
         r_state <= S_IDLE;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_red   = r_out_red;
   assign bus.out_mode  = r_out_mode;
   assign bus.out_beats = r_out_beats;
endmodule

// File: tb/tb_logic_reduce.sv
// Bench for logic_reduce: packet table with scoreboard, plus
// backpressure, reset and counter-saturation sequences.
module tb_logic_reduce;
   logic clk;
   logic rst;

   logic_reduce_if #(.WIDTH(8), .CNT_W(8)) bus ();
   logic_reduce_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

   logic_reduce #(.WIDTH(8), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic_reduce #(.WIDTH(8), .CNT_W(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         n;
      logic [7:0] d [4];
      logic [2:0] m [4];
      logic [7:0] ed;
      logic       er;
      logic [7:0] eb;
      logic [2:0] em;
   } vec_t;

   typedef struct {
      logic [7:0] ed;
      logic       er;
      logic [7:0] eb;
      logic [2:0] em;
   } exp_t;

   exp_t q[$];
   int   errs;
   int   checks;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] ed, input logic er,
                       input logic [7:0] eb, input logic [2:0] em);
      exp_t e;
      e.ed = ed;
      e.er = er;
      e.eb = eb;
      e.em = em;
      q.push_back(e);
   endtask

   // Result monitor: a result is consumed at the next posedge.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_result: got %0h expected none",
                     bus.out_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_data",  bus.out_data,  e.ed);
            chk("out_red",   bus.out_red,   e.er);
            chk("out_beats", bus.out_beats, e.eb);
            chk("out_mode",  bus.out_mode,  e.em);
         end
      end
   end

   task automatic beat(input logic [7:0] d, input logic [2:0] m,
                       input logic l);
      int t;
      t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.mode     = m;
      bus.in_last  = l;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         @(posedge clk);
         #1 bus.out_ready = 1'b1;
         t++;
         if (t > 50) begin
            checks++;
            errs++;
            $display("FAIL beat_timeout: got stalled expected accept");
            break;
         end
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      bus.out_ready = 1'b1;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      #1 chk("drain", q.size(), 0);
   endtask

   vec_t tv [10];

   initial begin
      errs   = 0;
      checks = 0;
      tv[0] = '{1, '{8'h00, 8'h00, 8'h00, 8'h00}, '{3'd0, 3'd0, 3'd0, 3'd0},
                8'h00, 1'b0, 8'd1, 3'd0};
      tv[1] = '{1, '{8'h00, 8'h00, 8'h00, 8'h00}, '{3'd1, 3'd0, 3'd0, 3'd0},
                8'hFF, 1'b1, 8'd1, 3'd1};
      tv[2] = '{3, '{8'hF0, 8'h3C, 8'hFF, 8'h00}, '{3'd2, 3'd2, 3'd2, 3'd0},
                8'h30, 1'b0, 8'd3, 3'd2};
      tv[3] = '{3, '{8'hF0, 8'h3C, 8'hFF, 8'h00}, '{3'd3, 3'd3, 3'd3, 3'd0},
                8'hCF, 1'b1, 8'd3, 3'd3};
      tv[4] = '{2, '{8'h0F, 8'h01, 8'h00, 8'h00}, '{3'd4, 3'd4, 3'd0, 3'd0},
                8'h0E, 1'b1, 8'd2, 3'd4};
      tv[5] = '{2, '{8'h0F, 8'h01, 8'h00, 8'h00}, '{3'd5, 3'd5, 3'd0, 3'd0},
                8'hF1, 1'b0, 8'd2, 3'd5};
      tv[6] = '{2, '{8'h0F, 8'h01, 8'h00, 8'h00}, '{3'd4, 3'd2, 3'd0, 3'd0},
                8'h0E, 1'b1, 8'd2, 3'd4};
      tv[7] = '{1, '{8'hA5, 8'h00, 8'h00, 8'h00}, '{3'd6, 3'd0, 3'd0, 3'd0},
                8'hA5, 1'b1, 8'd1, 3'd6};
      tv[8] = '{2, '{8'hFF, 8'hFF, 8'h00, 8'h00}, '{3'd3, 3'd3, 3'd0, 3'd0},
                8'h00, 1'b0, 8'd2, 3'd3};
      tv[9] = '{4, '{8'h81, 8'h00, 8'h40, 8'h02}, '{3'd7, 3'd1, 3'd1, 3'd1},
                8'hC3, 1'b1, 8'd4, 3'd7};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.mode      = '0;
      bus.out_ready = 1'b0;
      bus2.in_valid  = 1'b0;
      bus2.in_data   = '0;
      bus2.in_last   = 1'b0;
      bus2.mode      = '0;
      bus2.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  bus.in_ready,  0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data",  bus.out_data,  0);
      chk("rst_out_red",   bus.out_red,   0);
      chk("rst_out_mode",  bus.out_mode,  0);
      chk("rst_out_beats", bus.out_beats, 0);
      rst = 1'b0;
      #1 chk("idle_in_ready", bus.in_ready, 1);

      for (int i = 0; i < 10; i++) begin
         for (int b = 0; b < tv[i].n; b++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1 bus.out_ready = ($urandom_range(0, 2) != 0);
            if (b == tv[i].n - 1)
               push(tv[i].ed, tv[i].er, tv[i].eb, tv[i].em);
            beat(tv[i].d[b], tv[i].m[b], b == tv[i].n - 1);
         end
      end
      drain();

      bus.out_ready = 1'b0;
      push(8'hAA, 1'b1, 8'd1, 3'd0);
      beat(8'hAA, 3'd0, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h0F;
      bus.mode     = 3'd1;
      bus.in_last  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_in_ready",  bus.in_ready,  0);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_out_data",  bus.out_data,  8'hAA);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      push(8'hF0, 1'b0, 8'd1, 3'd1);
      beat(8'h0F, 3'd1, 1'b1);
      chk("swap_out_valid", bus.out_valid, 1);
      for (int k = 0; k < 4; k++) begin
         push(8'(k * 3 + 1), 1'b1, 8'd1, 3'd0);
         beat(8'(k * 3 + 1), 3'd0, 1'b1);
         chk("b2b_out_valid", bus.out_valid, 1);
      end
      drain();

      beat(8'h01, 3'd0, 1'b0);
      beat(8'h02, 3'd0, 1'b0);
      rst = 1'b1;
      #1 chk("midrst_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_out_valid", bus.out_valid, 0);
      push(8'h80, 1'b1, 8'd1, 3'd0);
      beat(8'h80, 3'd0, 1'b1);
      drain();

      for (int k = 0; k < 5; k++) begin
         bus2.in_valid = 1'b1;
         bus2.in_data  = 8'(1 << k);
         bus2.in_last  = (k == 4);
         @(posedge clk);
         #1;
      end
      bus2.in_valid = 1'b0;
      chk("sat_out_valid", bus2.out_valid, 1);
      chk("sat_out_data",  bus2.out_data,  8'h1F);
      chk("sat_out_red",   bus2.out_red,   1);
      chk("sat_out_beats", bus2.out_beats, 3);
      @(posedge clk);
      #1 chk("sat_consumed", bus2.out_valid, 0);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
